// File: rtl/typing_session.sv
// -----------------------------------------------------------------------------
// typing_session
// Typing-practice session controller. A target sentence is read byte by byte
// from an external combinational ROM. Each received key is compared with the
// current sentence character; correct keys are echoed over the UART and advance
// the pointer, wrong keys bump a saturating error counter. A BCD stopwatch
// measures the time from the first key until the sentence terminator (0x00)
// is reached. In DONE, a carriage return (0x0D) re-arms the session.
//
// Optional build macro:
//   TYPING_MISMATCH_ECHO_EN - wrong keys transmit BEL (0x07) instead of
//                             being silently counted.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   w_RX_DV         one-cycle strobe: w_RX_Byte valid
//   w_RX_Byte       received key
//   tx_done         UART transmit complete
//   sel             sentence select (sampled in IDLE only)
//   rom_addr        sentence ROM address
//   rom_data        ROM data for rom_addr, same cycle
//   out_byte        byte to transmit
//   uart_tx_go      transmit request
//   time_bcd        packed BCD elapsed time, digit 0 = deciseconds
//   err_count       saturating mismatch count
//   done            sentence complete
//   time_ovf        stopwatch saturated at all nines (sticky)
// -----------------------------------------------------------------------------
module typing_session #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned SHIFT    = 9,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned TICK_DIV = 10000000,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_RX_DV,
    input  logic [7:0]            w_RX_Byte,
    input  logic                  tx_done,
    input  logic [SEL_W-1:0]      sel,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [7:0]            rom_data,
    output logic [7:0]            out_byte,
    output logic                  uart_tx_go,
    output logic [4*DIGITS-1:0]   time_bcd,
    output logic [ERR_W-1:0]      err_count,
    output logic                  done,
    output logic                  time_ovf
);

    localparam int unsigned TIME_W = 4 * DIGITS;
    localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [7:0] CR = 8'h0D;
`ifdef TYPING_MISMATCH_ECHO_EN
    localparam logic [7:0] BEL = 8'h07;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TX   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0] base_sel;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        out_d;
    logic              go_d;
    logic [ERR_W-1:0]  err_d;
    logic [ERR_W-1:0]  err_inc;
    logic              sw_clear;
    logic              ret_run;
    logic              bel_d;

    logic [PRE_W-1:0]  presc, presc_d;
    logic [TIME_W-1:0] time_d;
    logic              ovf_d;
    logic              running;
    logic              tick;
    logic              all_nine;
    logic              carry;

    // Sentence base address for the currently selected slot
    assign base_sel = ADDR_W'(sel) << SHIFT;

    // Saturating error increment
    assign err_inc = (err_count == {ERR_W{1'b1}}) ? err_count : err_count + ERR_W'(1);

`ifdef TYPING_MISMATCH_ECHO_EN
    // Remembers that the current TX carries a BEL, so return goes to RUN
    logic bel_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            bel_q <= 1'b0;
        end else begin
            bel_q <= bel_d;
        end
    end
    assign ret_run = bel_q;
`else
    assign ret_run = 1'b0;
`endif

    // Next-state and datapath decisions
    always_comb begin
        state_d  = state;
        addr_d   = rom_addr;
        out_d    = out_byte;
        go_d     = 1'b0;
        err_d    = err_count;
        sw_clear = 1'b0;
        bel_d    = 1'b0;

        case (state)
            IDLE: begin
                addr_d = base_sel;
                if (w_RX_DV) begin
                    sw_clear = 1'b1;
                    err_d    = '0;
                    if (rom_data == 8'h00) begin
                        state_d = DONE;
                    end else if (w_RX_Byte == rom_data) begin
                        out_d   = w_RX_Byte;
                        addr_d  = rom_addr + ADDR_W'(1);
                        state_d = TX;
                    end else begin
                        // First key was wrong: count it against a fresh counter
                        err_d  = ERR_W'(1);
                        addr_d = rom_addr;
`ifdef TYPING_MISMATCH_ECHO_EN
                        out_d   = BEL;
                        bel_d   = 1'b1;
                        state_d = TX;
`else
                        state_d = RUN;
`endif
                    end
                end
            end

            RUN: begin
                if (w_RX_DV) begin
                    if (w_RX_Byte == rom_data) begin
                        out_d   = w_RX_Byte;
                        addr_d  = rom_addr + ADDR_W'(1);
                        state_d = TX;
                    end else begin
                        err_d = err_inc;
`ifdef TYPING_MISMATCH_ECHO_EN
                        out_d   = BEL;
                        bel_d   = 1'b1;
                        state_d = TX;
`endif
                    end
                end
            end

            TX: begin
                // Request is raised one cycle after entry and held until tx_done
                bel_d = ret_run;
                go_d  = 1'b1;
                if (uart_tx_go && tx_done) begin
                    go_d  = 1'b0;
                    bel_d = 1'b0;
                    if (ret_run || (rom_data != 8'h00)) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (w_RX_DV && (w_RX_Byte == CR)) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stopwatch: prescaler and BCD digit chain
    assign running  = (state == RUN) || (state == TX);
    assign tick     = running && (presc == PRE_LAST);
    assign all_nine = (time_bcd == {DIGITS{4'd9}});

    always_comb begin
        presc_d = presc;
        time_d  = time_bcd;
        ovf_d   = time_ovf;
        carry   = 1'b0;

        if (sw_clear) begin
            // A start always clears, even if a tick coincides
            presc_d = '0;
            time_d  = '0;
            ovf_d   = 1'b0;
        end else if (running) begin
            presc_d = tick ? '0 : presc + PRE_W'(1);
            if (tick) begin
                if (all_nine) begin
                    ovf_d = 1'b1;
                end else begin
                    carry = 1'b1;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (carry) begin
                            if (time_bcd[4*i +: 4] == 4'd9) begin
                                time_d[4*i +: 4] = 4'd0;
                            end else begin
                                time_d[4*i +: 4] = time_bcd[4*i +: 4] + 4'd1;
                                carry = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rom_addr   <= base_sel;
            out_byte   <= 8'h00;
            uart_tx_go <= 1'b0;
            err_count  <= '0;
            done       <= 1'b0;
            presc      <= '0;
            time_bcd   <= '0;
            time_ovf   <= 1'b0;
        end else begin
            state      <= state_d;
            rom_addr   <= addr_d;
            out_byte   <= out_d;
            uart_tx_go <= go_d;
            err_count  <= err_d;
            done       <= (state_d == DONE);
            presc      <= presc_d;
            time_bcd   <= time_d;
            time_ovf   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_typing_session.sv
// -----------------------------------------------------------------------------
// tb_typing_session
// Directed bench for typing_session with a small stopwatch (TICK_DIV=4,
// DIGITS=2). A ROM array feeds rom_data, and a UART responder logs every
// requested byte and answers with tx_done 20 cycles after the request.
// -----------------------------------------------------------------------------
module tb_typing_session;

    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned SHIFT    = 9;
    localparam int unsigned DIGITS   = 2;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned ERR_W    = 8;
    localparam int unsigned TX_LAT   = 20;

    logic                  clk;
    logic                  rst;
    logic                  w_RX_DV;
    logic [7:0]            w_RX_Byte;
    logic                  tx_done;
    logic [SEL_W-1:0]      sel;
    logic [ADDR_W-1:0]     rom_addr;
    logic [7:0]            rom_data;
    logic [7:0]            out_byte;
    logic                  uart_tx_go;
    logic [4*DIGITS-1:0]   time_bcd;
    logic [ERR_W-1:0]      err_count;
    logic                  done;
    logic                  time_ovf;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] tx_log [$];

    int n_checks = 0;
    int n_pass   = 0;

    typing_session #(
        .ADDR_W(ADDR_W), .SEL_W(SEL_W), .SHIFT(SHIFT),
        .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst(rst), .w_RX_DV(w_RX_DV), .w_RX_Byte(w_RX_Byte),
        .tx_done(tx_done), .sel(sel), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_byte(out_byte), .uart_tx_go(uart_tx_go), .time_bcd(time_bcd),
        .err_count(err_count), .done(done), .time_ovf(time_ovf)
    );

    assign rom_data = mem[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle key strobe; returns 1 unit after the sampling edge
    task automatic send_key(input logic [7:0] b);
        w_RX_Byte = b;
        w_RX_DV   = 1'b1;
        @(posedge clk);
        #1;
        w_RX_DV   = 1'b0;
    endtask

    function automatic logic [7:0] log_at(input int i);
        if (i < tx_log.size()) return tx_log[i];
        return 8'hEE;
    endfunction

    // UART model: log the byte, answer tx_done after TX_LAT cycles
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (uart_tx_go) begin
                tx_log.push_back(out_byte);
                repeat (TX_LAT) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        mem[11'h000] = 8'h61;                          // slot 0: "a"
        mem[11'h200] = 8'h61; mem[11'h201] = 8'h62;    // slot 1: "ab"
        // slot 2 stays empty
        mem[11'h600] = 8'h61; mem[11'h601] = 8'h62;    // slot 3: "abcd"
        mem[11'h602] = 8'h63; mem[11'h603] = 8'h64;

        rst = 1'b1; w_RX_DV = 1'b0; w_RX_Byte = 8'h00; sel = 2'd1;

        // Reset values
        step(3);
        check("rst_go",   32'(uart_tx_go), 32'h0);
        check("rst_out",  32'(out_byte),   32'h00);
        check("rst_time", 32'(time_bcd),   32'h00);
        check("rst_err",  32'(err_count),  32'h00);
        check("rst_done", 32'(done),       32'h0);
        check("rst_ovf",  32'(time_ovf),   32'h0);
        check("rst_addr", 32'(rom_addr),   32'h200);
        rst = 1'b0;
        step(2);

        // Slot 1 "ab": two correct keys
        send_key(8'h61);
        check("ab_go_entry", 32'(uart_tx_go), 32'h0);
        check("ab_out_a",    32'(out_byte),   32'h61);
        step(1);
        check("ab_go_next",  32'(uart_tx_go), 32'h1);
        step(28);
        send_key(8'h62);
        step(30);
        check("ab_log_n",  32'(tx_log.size()), 32'd2);
        check("ab_log0",   32'(log_at(0)),     32'h61);
        check("ab_log1",   32'(log_at(1)),     32'h62);
        check("ab_done",   32'(done),          32'h1);
        check("ab_err",    32'(err_count),     32'h00);
        check("ab_addr",   32'(rom_addr),      32'h202);
        sel = 2'd0;                                    // ignored outside IDLE
        step(1);
        check("ab_addr_hold", 32'(rom_addr), 32'h202);
        send_key(8'h0D);
        check("cr_done", 32'(done), 32'h0);
        step(2);

        // Slot 0 "a": wrong key then right key
        tx_log.delete();
        send_key(8'h78);
        check("mm_err1", 32'(err_count), 32'h01);
        step(30);
        send_key(8'h61);
        step(30);
        check("mm_err",  32'(err_count), 32'h01);
        check("mm_done", 32'(done),      32'h1);
`ifdef TYPING_MISMATCH_ECHO_EN
        check("mm_log_n", 32'(tx_log.size()), 32'd2);
        check("mm_log0",  32'(log_at(0)),     32'h07);
        check("mm_log1",  32'(log_at(1)),     32'h61);
`else
        check("mm_log_n", 32'(tx_log.size()), 32'd1);
        check("mm_log0",  32'(log_at(0)),     32'h61);
`endif
        sel = 2'd2;
        send_key(8'h0D);
        step(2);

        // Slot 2 empty: any key finishes immediately
        tx_log.delete();
        send_key(8'h71);
        check("empty_done", 32'(done),       32'h1);
        check("empty_time", 32'(time_bcd),   32'h00);
        check("empty_err",  32'(err_count),  32'h00);
        check("empty_go",   32'(uart_tx_go), 32'h0);
        step(5);
        check("empty_go5",  32'(uart_tx_go),     32'h0);
        check("empty_log",  32'(tx_log.size()),  32'd0);
        sel = 2'd3;
        send_key(8'h0D);
        check("empty_cr", 32'(done), 32'h0);
        step(2);

        // Slot 3: keys during TX ignored, stopwatch timing and saturation
        tx_log.delete();
        send_key(8'h61);                               // edge E0
        step(4);                                       // E4
        send_key(8'h62);                               // E5, in TX
        step(2);
        send_key(8'h7A);                               // E8, in TX
        check("txign_err", 32'(err_count), 32'h00);
        step(32);                                      // E40: 10 ticks
        check("sw_time40", 32'(time_bcd),       32'h10);
        check("txign_addr", 32'(rom_addr),      32'h601);
        check("txign_log",  32'(tx_log.size()), 32'd1);
        check("sw_ovf40",  32'(time_ovf),       32'h0);
        step(960);                                     // E1000
        check("sw_time_sat", 32'(time_bcd), 32'h99);
        check("sw_ovf",      32'(time_ovf), 32'h1);
        check("sw_done",     32'(done),     32'h0);

        // Reset while transmitting
        send_key(8'h62);
        step(1);
        check("rtx_go_pre", 32'(uart_tx_go), 32'h1);
        rst = 1'b1;
        step(1);
        check("rtx_go",   32'(uart_tx_go), 32'h0);
        check("rtx_out",  32'(out_byte),   32'h00);
        check("rtx_time", 32'(time_bcd),   32'h00);
        check("rtx_err",  32'(err_count),  32'h00);
        check("rtx_done", 32'(done),       32'h0);
        check("rtx_ovf",  32'(time_ovf),   32'h0);
        check("rtx_addr", 32'(rom_addr),   32'h600);
        rst = 1'b0;
        step(3);
        check("rtx_go_after", 32'(uart_tx_go), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
